// File: rtl/full_register_slice_pkg.sv
// Shared definitions for the full register slice: state encodings, which double as
// occupancy counts, and a small helper for the upstream-ready decision.
package full_register_slice_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    // Upstream may push whenever the skid entry is free.
    function automatic logic st_accepts(input logic [1:0] st);
        return st != ST_FULL;
    endfunction

endpackage

// File: rtl/full_register_slice_rv_data_reg.sv
// Enable-load payload register with asynchronous clear; used for both the output
// entry and the skid entry of the slice.
module full_register_slice_rv_data_reg #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/full_register_slice.sv
// Two-entry valid/ready skid slice: every output comes straight from a flop, so both the
// forward (valid/data) and backward (ready) paths are cut while sustaining one beat per cycle.
module full_register_slice
    import full_register_slice_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ready_out,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  ready_in,
    output logic [1:0]            occupancy
);

    logic [1:0]            r_state;
    logic                  r_valid;
    logic                  r_ready;
    logic [1:0]            w_state_nxt;
    logic                  w_up_xfer;
    logic                  w_dn_xfer;
    logic                  w_out_load;
    logic                  w_skid_load;
    logic                  w_out_sel_skid;
    logic [DATA_WIDTH-1:0] w_out_d;
    logic [DATA_WIDTH-1:0] w_skid_q;

    assign w_up_xfer = valid_in & r_ready;
    assign w_dn_xfer = r_valid & ready_in;

    always_comb begin
        w_state_nxt    = r_state;
        w_out_load     = 1'b0;
        w_skid_load    = 1'b0;
        w_out_sel_skid = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_up_xfer) begin
                    w_state_nxt = ST_BUSY;
                    w_out_load  = 1'b1;
                end
            end
            ST_BUSY: begin
                if (w_up_xfer && w_dn_xfer) begin
                    w_out_load = 1'b1;
                end else if (w_up_xfer) begin
                    // Downstream stalled: park the new beat behind the presented one.
                    w_state_nxt = ST_FULL;
                    w_skid_load = 1'b1;
                end else if (w_dn_xfer) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (ready_in) begin
                    w_state_nxt    = ST_BUSY;
                    w_out_load     = 1'b1;
                    w_out_sel_skid = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    assign w_out_d = w_out_sel_skid ? w_skid_q : data_in;

    // ready_out stays low through reset and rises on the first edge after release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
            r_valid <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= (w_state_nxt != ST_EMPTY);
            r_ready <= st_accepts(w_state_nxt);
        end
    end

    full_register_slice_rv_data_reg #(.WIDTH(DATA_WIDTH)) u_out_reg (
        .i_clk (clk),
        .i_rst (reset),
        .i_en  (w_out_load),
        .i_d   (w_out_d),
        .o_q   (data_out)
    );

    full_register_slice_rv_data_reg #(.WIDTH(DATA_WIDTH)) u_skid_reg (
        .i_clk (clk),
        .i_rst (reset),
        .i_en  (w_skid_load),
        .i_d   (data_in),
        .o_q   (w_skid_q)
    );

    assign ready_out = r_ready;
    assign valid_out = r_valid;
    assign occupancy = r_state;

endmodule

// File: tb/tb_full_register_slice.sv
// Directed and randomised checks of the full register slice against hand-derived
// expectations and a scoreboard FIFO.
module tb_full_register_slice;

    logic       clk;
    logic       reset;
    logic       valid_in;
    logic [7:0] data_in;
    logic       ready_out;
    logic       valid_out;
    logic [7:0] data_out;
    logic       ready_in;
    logic [1:0] occupancy;

    int n_tests;
    int n_fail;

    full_register_slice #(.DATA_WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_out (ready_out),
        .valid_out (valid_out),
        .data_out  (data_out),
        .ready_in  (ready_in),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; outputs are examined 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; valid_in = 1'b1; data_in = 8'hEE; ready_in = 1'b1;
        step(); step();
        chk("rst_valid", {7'd0, valid_out}, 8'd0);
        chk("rst_ready", {7'd0, ready_out}, 8'd0);
        chk("rst_occ",   {6'd0, occupancy}, 8'd0);
        chk("rst_data",  data_out, 8'h00);
        valid_in = 1'b0;
        reset = 1'b0;
        #1;
        chk("rel_ready0", {7'd0, ready_out}, 8'd0);
        step();
        chk("rel_ready1", {7'd0, ready_out}, 8'd1);
        chk("rel_occ",    {6'd0, occupancy}, 8'd0);
        chk("rel_valid",  {7'd0, valid_out}, 8'd0);
    endtask

    task automatic test_streaming();
        ready_in = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            valid_in = 1'b1; data_in = 8'(i);
            step();
            chk("str_data",  data_out, 8'(i));
            chk("str_valid", {7'd0, valid_out}, 8'd1);
            chk("str_occ",   {6'd0, occupancy}, 8'd1);
            chk("str_ready", {7'd0, ready_out}, 8'd1);
        end
        valid_in = 1'b0; data_in = 8'hFF;
        step();
        chk("str_end_valid", {7'd0, valid_out}, 8'd0);
        chk("str_end_occ",   {6'd0, occupancy}, 8'd0);
    endtask

    task automatic test_backpressure();
        ready_in = 1'b1; valid_in = 1'b1; data_in = 8'hA0;
        step();
        chk("bp_a0", data_out, 8'hA0);
        ready_in = 1'b0; data_in = 8'hA1;
        step();
        chk("bp_hold_a0", data_out, 8'hA0);
        chk("bp_occ2",    {6'd0, occupancy}, 8'd2);
        chk("bp_ready0",  {7'd0, ready_out}, 8'd0);
        data_in = 8'hA2;
        step();
        chk("bp_full_a0", data_out, 8'hA0);
        chk("bp_full_occ", {6'd0, occupancy}, 8'd2);
        ready_in = 1'b1;
        step();
        chk("bp_a1",      data_out, 8'hA1);
        chk("bp_a1_occ",  {6'd0, occupancy}, 8'd1);
        chk("bp_a1_rdy",  {7'd0, ready_out}, 8'd1);
        step();
        chk("bp_a2",      data_out, 8'hA2);
        chk("bp_a2_vld",  {7'd0, valid_out}, 8'd1);
        valid_in = 1'b0;
        step();
        chk("bp_end_valid", {7'd0, valid_out}, 8'd0);
        chk("bp_end_occ",   {6'd0, occupancy}, 8'd0);
    endtask

    task automatic test_drain();
        ready_in = 1'b0; valid_in = 1'b1; data_in = 8'h5C;
        step();
        valid_in = 1'b0; data_in = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            chk("dr_data",  data_out, 8'h5C);
            chk("dr_valid", {7'd0, valid_out}, 8'd1);
            chk("dr_occ",   {6'd0, occupancy}, 8'd1);
            step();
        end
        ready_in = 1'b1;
        step();
        chk("dr_end_valid", {7'd0, valid_out}, 8'd0);
        chk("dr_end_occ",   {6'd0, occupancy}, 8'd0);
    endtask

    task automatic test_async_reset();
        ready_in = 1'b1; valid_in = 1'b1; data_in = 8'hA0;
        step();
        ready_in = 1'b0; data_in = 8'hA1;
        step();
        chk("ar_pre_occ", {6'd0, occupancy}, 8'd2);
        valid_in = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("ar_valid", {7'd0, valid_out}, 8'd0);
        chk("ar_ready", {7'd0, ready_out}, 8'd0);
        chk("ar_occ",   {6'd0, occupancy}, 8'd0);
        chk("ar_data",  data_out, 8'h00);
        step();
        reset = 1'b0; ready_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("ar_no_beat", {7'd0, valid_out}, 8'd0);
        end
        chk("ar_ready_back", {7'd0, ready_out}, 8'd1);
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        logic       up;
        logic       dn;
        for (int c = 0; c < 10000; c++) begin
            chk("rnd_occ",   {6'd0, occupancy}, 8'(q.size()));
            chk("rnd_ready", {7'd0, ready_out}, {7'd0, (q.size() != 2)});
            valid_in = 1'($urandom_range(0, 1));
            ready_in = ($urandom_range(0, 3) != 0);
            data_in  = 8'($urandom);
            up = valid_in & ready_out;
            dn = valid_out & ready_in;
            if (dn) begin
                if (q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL rnd_spurious: got 0x%0h, expected no beat", data_out);
                end else begin
                    chk("rnd_data", data_out, q.pop_front());
                end
            end
            if (up) q.push_back(data_in);
            step();
        end
        valid_in = 1'b0; ready_in = 1'b1;
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        reset = 1'b1; valid_in = 1'b0; data_in = 8'h00; ready_in = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_drain();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
